// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer around one shared round datapath.
//   Accepts plaintext/key in IDLE, then runs NUM_ROUNDS rounds as ISSUE (advance key) +
//   WAIT (ROUND_LAT cycles for the datapath) pairs, and presents the ciphertext in DONE
//   until it is taken.
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     in_valid_i/in_ready_o        plaintext (in_text_i) + key (in_key_i) handshake
//     out_valid_o/out_ready_i      ciphertext (out_text_o) handshake
//     busy_o, round_o              status: not IDLE, current round (0 in IDLE)
//     rd_state_o, rd_key_o         state and round key driven to the round datapath
//     rd_last_o, rd_start_o        final round (no MixColumns), first WAIT cycle pulse
//     rd_result_i                  round datapath output
//     ks_rcon_o, ks_next_key_i     rcon to, and next round key from, the key schedule
//     abort_i                      only with AES_CTRL_ABORT_EN: drop the block in flight
//   Optional feature macro: AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int ROUND_LAT  = 1,
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_CTRL_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_text_i,
  input  logic [127:0] in_key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_text_o,
  output logic         busy_o,
  output logic [3:0]   round_o,
  output logic [127:0] rd_state_o,
  output logic [127:0] rd_key_o,
  output logic         rd_last_o,
  output logic         rd_start_o,
  input  logic [127:0] rd_result_i,
  output logic [7:0]   ks_rcon_o,
  input  logic [127:0] ks_next_key_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fsm_t;
  localparam int CW = $clog2(ROUND_LAT + 1);
  fsm_t          fsm_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  state_q, key_q;
  logic [3:0]    round_q;
  logic [7:0]    rcon_q, rcon_d;
  logic          in_ready_q, out_valid_q, busy_q, rd_start_q, rd_last_q;
  logic          abort, last_wait, final_round;
`ifdef AES_CTRL_ABORT_EN
  assign abort = abort_i && (fsm_q != IDLE);
`else
  assign abort = 1'b0;
`endif
  // xtime in GF(2^8): next rcon of the key schedule
  assign rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign last_wait   = cnt_q == CW'(ROUND_LAT - 1);
  assign final_round = round_q == 4'(NUM_ROUNDS);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || abort) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      rcon_q      <= 8'h01;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_start_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid_i) begin
          state_q    <= in_text_i ^ in_key_i;
          key_q      <= in_key_i;
          round_q    <= 4'd1;
          rcon_q     <= 8'h01;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          fsm_q      <= ISSUE;
        end
        ISSUE: begin
          key_q      <= ks_next_key_i;
          cnt_q      <= '0;
          rd_start_q <= 1'b1;
          rd_last_q  <= final_round;
          fsm_q      <= WAIT;
        end
        WAIT: begin
          rd_start_q <= 1'b0;
          if (last_wait) begin
            state_q   <= rd_result_i;
            rd_last_q <= 1'b0;
            if (final_round) begin
              out_valid_q <= 1'b1;
              fsm_q       <= DONE;
            end else begin
              round_q <= round_q + 4'd1;
              rcon_q  <= rcon_d;
              fsm_q   <= ISSUE;
            end
          end else cnt_q <= cnt_q + CW'(1);
        end
        DONE: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          round_q     <= '0;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_text_o  = state_q;
  assign busy_o      = busy_q;
  assign round_o     = round_q;
  assign rd_state_o  = state_q;
  assign rd_key_o    = key_q;
  assign rd_last_o   = rd_last_q;
  assign rd_start_o  = rd_start_q;
  assign ks_rcon_o   = rcon_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl with a behavioural AES round and key schedule.
module tb_aes_round_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] in_text = '0, in_key = '0;
  logic         in_ready, out_valid, busy, rd_last, rd_start;
  logic [127:0] out_text, rd_state, rd_key, rd_result, ks_next_key;
  logic [3:0]   round;
  logic [7:0]   ks_rcon;
  int           compared = 0, mismatched = 0;
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [127:0] B_TXT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_R1  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_TXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_R1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_round_ctrl #(.ROUND_LAT(1), .NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_CTRL_ABORT_EN
    .abort_i(abort),
`endif
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_text_i(in_text), .in_key_i(in_key),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_text_o(out_text),
    .busy_o(busy), .round_o(round), .rd_state_o(rd_state), .rd_key_o(rd_key),
    .rd_last_o(rd_last), .rd_start_o(rd_start), .rd_result_i(rd_result),
    .ks_rcon_o(ks_rcon), .ks_next_key_i(ks_next_key)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] b = x;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      o[127-32*c -: 32] = last ? {a0, a1, a2, a3} :
        {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
         a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
         a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
         gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
    end
    return o ^ k;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign rd_result   = aes_round(rd_state, rd_key, rd_last);
  assign ks_next_key = key_step(rd_key, ks_rcon);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_round", round, 4'd0);
    chk("rst_rcon", ks_rcon, 8'h01);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rd_start", rd_start, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_rd_state", rd_state, 128'h0);
    chk("rst_rd_key", rd_key, 128'h0);
    chk("rst_out_text", out_text, 128'h0);
  endtask

  task automatic run(input logic [127:0] exp_r1, input logic [127:0] exp_ct);
    int n = 0, starts = 0, lasts = 0;
    while (!out_valid && n < 100) begin
      if (rd_start) begin
        starts++;
        chk("ks_rcon", ks_rcon, rcon_tab[int'(round) - 1]);
        chk("rd_last_round", rd_last, round == 4'd10);
        if (round == 4'd1) chk("rd_state_r1", rd_state, exp_r1);
      end
      if (rd_last) lasts++;
      step();
      n++;
    end
    chk("latency", n, 20);
    chk("rd_start_pulses", starts, 10);
    chk("rd_last_cycles", lasts, 1);
    chk("out_text", out_text, exp_ct);
    chk("done_in_ready", in_ready, 1'b0);
    chk("done_busy", busy, 1'b1);
  endtask

  initial begin
    step();
    step();
    chk_reset();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_text = B_TXT; in_key = B_KEY;
    step();
    in_valid = 1'b0;
    chk("issue_round", round, 4'd1);
    chk("issue_busy", busy, 1'b1);
    chk("issue_in_ready", in_ready, 1'b0);
    run(B_R1, B_CT);
    in_valid = 1'b1; in_text = C_TXT; in_key = C_KEY;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_text", out_text, B_CT);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 1'b0);
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_round", round, 4'd0);
    chk("hs_busy", busy, 1'b0);
    step();
    in_valid = 1'b0;
    chk("c_accept_round", round, 4'd1);
    run(C_R1, C_CT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_text = B_TXT; in_key = B_KEY;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 50 && !(rd_start && round == 4'd5); k++) step();
    chk("reach_r5_wait", rd_start && round == 4'd5, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_text = C_TXT; in_key = C_KEY;
    step();
    in_valid = 1'b0;
    run(C_R1, C_CT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    in_valid = 1'b1; in_text = B_TXT; in_key = B_KEY;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 50 && !(rd_start && round == 4'd3); k++) step();
    chk("reach_r3_wait", rd_start && round == 4'd3, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_reset();
    for (int i = 0; i < 25; i++) begin
      step();
      chk("abort_no_out", out_valid, 1'b0);
    end
    in_valid = 1'b1; in_text = B_TXT; in_key = B_KEY;
    step();
    in_valid = 1'b0;
    run(B_R1, B_CT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
